// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the load/store sequencer.
//   state_t    - sequencer FSM encoding (idle / transfer / done / error)
//   F3_*       - funct3 encodings of the RV32I load/store sizes
//   size_bytes - access size in bytes for a funct3 value
//   f3_legal   - whether a funct3 value is a legal load or store
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Only funct3[1:0] selects the size; 2'b11 is rejected by f3_legal.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        logic [2:0] n;
        case (funct3[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3);
        logic ok;
        if (is_store) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational sign/zero extension of assembled load data.
//   byte_buf  in  32  little-endian bytes of the load, byte 0 = lowest address
//   size      in  3   access size in bytes (1, 2 or 4)
//   sign_ext  in  1   1 = sign-extend, 0 = zero-extend
//   rdata     out 32  extended load result
module load_extend (
    input  logic [31:0] byte_buf,
    input  logic [2:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = byte_buf;
        case (size)
            3'd1: rdata = {{24{sign_ext & byte_buf[7]}}, byte_buf[7:0]};
            3'd2: rdata = {{16{sign_ext & byte_buf[15]}}, byte_buf[15:0]};
            default: rdata = byte_buf;
        endcase
    end

endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: splits one RV32I load/store into BUSW-wide memory beats, assembles and
// extends load data, and signals completion with a one-cycle ready (or err) pulse.
//   Parameters: MABL = memory word-address width, BUSW = memory data width (8/16/32).
//   clk, rst (sync, active-high)
//   req/store/funct3/addr/wdata  request side, sampled only in idle
//   busy/ready/err/rdata         status and load result
//   mem_rd/mem_we/mem_be/mem_wd/mem_ad  memory side; mem_rd valid one cycle after mem_ad
// Build option: define MEM_MISALIGN_TRAP_EN to reject misaligned accesses with err;
// otherwise the low address bits are cleared and the access proceeds.
module mem_sequencer
    import mem_pkg::*;
#(
    parameter int unsigned MABL = 19,
    parameter int unsigned BUSW = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req,
    input  logic                           store,
    input  logic [2:0]                     funct3,
    input  logic [MABL+$clog2(BUSW/8)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic                           busy,
    output logic                           ready,
    output logic                           err,
    output logic [31:0]                    rdata,
    input  logic [BUSW-1:0]                mem_rd,
    output logic                           mem_we,
    output logic [BUSW/8-1:0]              mem_be,
    output logic [BUSW-1:0]                mem_wd,
    output logic [MABL-1:0]                mem_ad
);

    localparam int unsigned Lanes = BUSW / 8;
    localparam int unsigned OffW  = $clog2(Lanes);
    localparam int unsigned AddrW = MABL + OffW;
    localparam int unsigned BeatW = $clog2(32 / BUSW) + 1;

    state_t state_q, state_d;

    logic             store_q;
    logic             sgn_q;
    logic [2:0]       size_q;
    logic [AddrW-1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [BeatW-1:0] last_q;
    logic [BeatW-1:0] beat_q;
    logic             cap_q;       // mem_rd this cycle belongs to load beat cap_beat_q
    logic [BeatW-1:0] cap_beat_q;
    logic [31:0]      buf_q;
    logic [31:0]      rdata_q;

    // Request decode
    logic [2:0]       req_size;
    logic [1:0]       low_mask;
    logic [AddrW-1:0] req_addr;
    logic [BeatW-1:0] req_last;
    logic             illegal;

    always_comb begin
        req_size      = size_bytes(funct3);
        low_mask      = 2'(req_size - 3'd1);
        req_addr      = addr;
        req_addr[1:0] = addr[1:0] & ~low_mask;
        illegal       = !f3_legal(store, funct3);
`ifdef MEM_MISALIGN_TRAP_EN
        illegal = illegal || ((addr[1:0] & low_mask) != 2'b00);
`endif
        if (int'(req_size) > int'(Lanes)) begin
            req_last = BeatW'(int'(req_size) / int'(Lanes) - 1);
        end else begin
            req_last = '0;
        end
    end

    // Lane of the first byte; non-zero only for single-beat sub-bus accesses.
    logic [1:0] lane_off;
    assign lane_off = addr_q[1:0] & 2'(Lanes - 1);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = illegal ? StErr : StXfer;
                end
            end
            StXfer: begin
                if (beat_q == last_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers
    logic [31:0] buf_merged;
    logic [31:0] rdata_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q    <= 1'b0;
            sgn_q      <= 1'b0;
            size_q     <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_q     <= '0;
            beat_q     <= '0;
            cap_q      <= 1'b0;
            cap_beat_q <= '0;
            buf_q      <= '0;
            rdata_q    <= '0;
        end else begin
            if (state_q == StIdle && req && !illegal) begin
                store_q <= store;
                sgn_q   <= !funct3[2];
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= wdata;
                last_q  <= req_last;
            end
            beat_q     <= (state_q == StXfer) ? beat_q + 1'b1 : '0;
            cap_q      <= (state_q == StXfer) && !store_q;
            cap_beat_q <= beat_q;
            if (cap_q) begin
                buf_q <= buf_merged;
            end
            if (state_q == StDone && !store_q) begin
                rdata_q <= rdata_ext;
            end
        end
    end

    // Merge the beat currently on mem_rd into the byte buffer, so the final beat is
    // usable in the DONE cycle itself.
    always_comb begin
        int idx;
        idx        = 0;
        buf_merged = buf_q;
        if (cap_q) begin
            for (int j = 0; j < int'(Lanes); j++) begin
                idx = int'(cap_beat_q) * int'(Lanes) + j - int'(lane_off);
                if (idx >= 0 && idx < int'(size_q)) begin
                    buf_merged[8*idx +: 8] = mem_rd[8*j +: 8];
                end
            end
        end
    end

    load_extend u_load_extend (
        .byte_buf (buf_merged),
        .size     (size_q),
        .sign_ext (sgn_q),
        .rdata    (rdata_ext)
    );

    // FSM: outputs
    always_comb begin
        int idx;
        int wsel;
        idx    = 0;
        wsel   = 0;
        busy   = (state_q != StIdle);
        ready  = (state_q == StDone);
        err    = (state_q == StErr);
        rdata  = (state_q == StDone && !store_q) ? rdata_ext : rdata_q;
        mem_we = 1'b0;
        mem_be = '0;
        mem_wd = '0;
        mem_ad = '0;
        if (state_q == StXfer) begin
            mem_we = store_q;
            mem_ad = MABL'(addr_q >> OffW) + MABL'(beat_q);
            for (int j = 0; j < int'(Lanes); j++) begin
                idx = int'(beat_q) * int'(Lanes) + j - int'(lane_off);
                if (idx >= 0 && idx < int'(size_q)) begin
                    mem_be[j] = 1'b1;
                end
                // Narrow stores replicate their bytes across all lanes.
                wsel = (int'(beat_q) * int'(Lanes) + j) & (int'(size_q) - 1);
                mem_wd[8*j +: 8] = wdata_q[8*wsel +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed checks of mem_sequencer at BUSW = 8, 16 and 32, each with a
// small byte-addressed memory model (registered read, byte-lane write).
module tb_mem_sequencer;
    import mem_pkg::*;

    logic clk;
    logic rst;

    logic [2:0]  req_a;
    logic [2:0]  store_a;
    logic [2:0]  f3_a    [3];
    logic [20:0] addr_a  [3];
    logic [31:0] wdata_a [3];

    logic [2:0]  busy_a;
    logic [2:0]  ready_a;
    logic [2:0]  err_a;
    logic [2:0]  we_a;
    logic [31:0] rdata_a [3];
    logic [18:0] ad_a    [3];
    logic [3:0]  be_a    [3];
    logic [31:0] wd_a    [3];

    int n_checks;
    int n_pass;

    // Per-operation log of every beat cycle
    int          log_n;
    int          we_n;
    logic [18:0] log_ad [8];
    logic [3:0]  log_be [8];
    logic [31:0] log_wd [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned BW  = 8 << g;
        localparam int unsigned LN  = BW / 8;
        localparam int unsigned AWL = 19 + $clog2(LN);

        logic          busy_l, ready_l, err_l, we_l;
        logic [31:0]   rdata_l;
        logic [BW-1:0] rd_l, wd_l;
        logic [LN-1:0] be_l;
        logic [18:0]   ad_l;
        logic [7:0]    mem [256];

        mem_sequencer #(
            .MABL (19),
            .BUSW (BW)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .req    (req_a[g]),
            .store  (store_a[g]),
            .funct3 (f3_a[g]),
            .addr   (addr_a[g][AWL-1:0]),
            .wdata  (wdata_a[g]),
            .busy   (busy_l),
            .ready  (ready_l),
            .err    (err_l),
            .rdata  (rdata_l),
            .mem_rd (rd_l),
            .mem_we (we_l),
            .mem_be (be_l),
            .mem_wd (wd_l),
            .mem_ad (ad_l)
        );

        always @(posedge clk) begin
            for (int j = 0; j < int'(LN); j++) begin
                if (we_l && be_l[j]) mem[8'(ad_l * LN + j)] <= wd_l[8*j +: 8];
                rd_l[8*j +: 8] <= mem[8'(ad_l * LN + j)];
            end
        end

        assign busy_a[g]  = busy_l;
        assign ready_a[g] = ready_l;
        assign err_a[g]   = err_l;
        assign we_a[g]    = we_l;
        assign rdata_a[g] = rdata_l;
        assign ad_a[g]    = ad_l;
        assign be_a[g]    = 4'(be_l);
        assign wd_a[g]    = 32'(wd_l);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance g, log beats, check latency and the completion pulse.
    task automatic do_op(input int g, input logic st, input logic [2:0] f3,
                         input logic [20:0] a, input logic [31:0] wd, input string tag,
                         input int exp_lat, input logic exp_err);
        int   lat;
        logic done;
        log_n = 0;
        we_n  = 0;
        @(negedge clk);
        req_a[g]   = 1'b1;
        store_a[g] = st;
        f3_a[g]    = f3;
        addr_a[g]  = a;
        wdata_a[g] = wd;
        @(negedge clk);
        req_a[g] = 1'b0;
        lat  = 1;
        done = 1'b0;
        while (!done && lat <= 12) begin
            if (ready_a[g] || err_a[g]) begin
                done = 1'b1;
            end else begin
                if (log_n < 8) begin
                    log_ad[log_n] = ad_a[g];
                    log_be[log_n] = be_a[g];
                    log_wd[log_n] = wd_a[g];
                end
                log_n++;
                if (we_a[g]) we_n++;
                @(negedge clk);
                lat++;
            end
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".err"}, 32'(err_a[g]), 32'(exp_err));
        check({tag, ".rdy"}, 32'(ready_a[g]), 32'(!exp_err));
        @(negedge clk);
        check({tag, ".idle"}, 32'({busy_a[g], ready_a[g], err_a[g]}), 32'h0);
    endtask

    initial begin
        int seen_rdy;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        req_a    = '0;
        store_a  = '0;
        for (int g = 0; g < 3; g++) begin
            f3_a[g]    = 3'b000;
            addr_a[g]  = '0;
            wdata_a[g] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("rst.ctl", 32'({busy_a[g], ready_a[g], err_a[g], we_a[g]}), 32'h0);
            check("rst.rdata", rdata_a[g], 32'h0);
            check("rst.ad", 32'(ad_a[g]), 32'h0);
            check("rst.be", 32'(be_a[g]), 32'h0);
            check("rst.wd", wd_a[g], 32'h0);
        end

        // ---------------- BUSW = 8 ----------------
        do_op(0, 1'b1, F3_B, 21'h3, 32'h80, "sb8", 2, 1'b0);
        check("sb8.we", 32'(we_n), 32'd1);
        check("sb8.ad", 32'(log_ad[0]), 32'h3);
        check("sb8.be", 32'(log_be[0]), 32'h1);
        check("sb8.wd", log_wd[0], 32'h80);

        do_op(0, 1'b0, F3_B, 21'h3, 32'h0, "lb8", 2, 1'b0);
        check("lb8.rdata", rdata_a[0], 32'hFFFF_FF80);
        check("lb8.we", 32'(we_n), 32'd0);
        do_op(0, 1'b0, F3_BU, 21'h3, 32'h0, "lbu8", 2, 1'b0);
        check("lbu8.rdata", rdata_a[0], 32'h0000_0080);

        do_op(0, 1'b1, F3_W, 21'h10, 32'hDEAD_BEEF, "sw8", 5, 1'b0);
        check("sw8.we", 32'(we_n), 32'd4);
        check("sw8.ad0", 32'(log_ad[0]), 32'h10);
        check("sw8.ad3", 32'(log_ad[3]), 32'h13);
        check("sw8.wd0", log_wd[0], 32'hEF);
        check("sw8.wd1", log_wd[1], 32'hBE);
        check("sw8.wd2", log_wd[2], 32'hAD);
        check("sw8.wd3", log_wd[3], 32'hDE);
        check("sw8.rdata_kept", rdata_a[0], 32'h0000_0080);

        do_op(0, 1'b0, F3_W, 21'h10, 32'h0, "lw8", 5, 1'b0);
        check("lw8.rdata", rdata_a[0], 32'hDEAD_BEEF);
        do_op(0, 1'b0, F3_H, 21'h12, 32'h0, "lh8", 3, 1'b0);
        check("lh8.ad0", 32'(log_ad[0]), 32'h12);
        check("lh8.rdata", rdata_a[0], 32'hFFFF_DEAD);
        do_op(0, 1'b0, F3_HU, 21'h10, 32'h0, "lhu8", 3, 1'b0);
        check("lhu8.rdata", rdata_a[0], 32'h0000_BEEF);

        do_op(0, 1'b0, 3'b011, 21'h0, 32'h0, "ill_ld", 1, 1'b1);
        check("ill_ld.beats", 32'(log_n), 32'd0);
        check("ill_ld.rdata_kept", rdata_a[0], 32'h0000_BEEF);
        do_op(0, 1'b1, 3'b100, 21'h0, 32'h0, "ill_st", 1, 1'b1);
        check("ill_st.we", 32'(we_n), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        do_op(0, 1'b0, F3_W, 21'h12, 32'h0, "mis_lw", 1, 1'b1);
        check("mis_lw.beats", 32'(log_n), 32'd0);
        check("mis_lw.rdata_kept", rdata_a[0], 32'h0000_BEEF);
`else
        do_op(0, 1'b0, F3_W, 21'h12, 32'h0, "mis_lw", 5, 1'b0);
        check("mis_lw.ad0", 32'(log_ad[0]), 32'h10);
        check("mis_lw.rdata", rdata_a[0], 32'hDEAD_BEEF);
`endif

        // ---------------- BUSW = 16 ----------------
        do_op(1, 1'b1, F3_H, 21'h2, 32'h8001, "sh16", 2, 1'b0);
        check("sh16.ad", 32'(log_ad[0]), 32'h1);
        check("sh16.be", 32'(log_be[0]), 32'h3);
        check("sh16.wd", log_wd[0], 32'h8001);
        do_op(1, 1'b0, F3_H, 21'h2, 32'h0, "lh16", 2, 1'b0);
        check("lh16.ad", 32'(log_ad[0]), 32'h1);
        check("lh16.be", 32'(log_be[0]), 32'h3);
        check("lh16.rdata", rdata_a[1], 32'hFFFF_8001);

        do_op(1, 1'b1, F3_W, 21'h4, 32'h1234_5678, "sw16", 3, 1'b0);
        check("sw16.ad0", 32'(log_ad[0]), 32'h2);
        check("sw16.wd0", log_wd[0], 32'h5678);
        check("sw16.ad1", 32'(log_ad[1]), 32'h3);
        check("sw16.wd1", log_wd[1], 32'h1234);
        do_op(1, 1'b0, F3_B, 21'h5, 32'h0, "lb16", 2, 1'b0);
        check("lb16.be", 32'(log_be[0]), 32'h2);
        check("lb16.rdata", rdata_a[1], 32'h0000_0056);
        do_op(1, 1'b0, F3_W, 21'h4, 32'h0, "lw16", 3, 1'b0);
        check("lw16.rdata", rdata_a[1], 32'h1234_5678);

        // ---------------- BUSW = 32 ----------------
        do_op(2, 1'b1, F3_B, 21'h6, 32'h5A, "sb32", 2, 1'b0);
        check("sb32.ad", 32'(log_ad[0]), 32'h1);
        check("sb32.be", 32'(log_be[0]), 32'h4);
        check("sb32.lane2", 32'(log_wd[0][23:16]), 32'h5A);
        do_op(2, 1'b0, F3_BU, 21'h6, 32'h0, "lbu32", 2, 1'b0);
        check("lbu32.rdata", rdata_a[2], 32'h0000_005A);
        do_op(2, 1'b1, F3_W, 21'h8, 32'hCAFE_F00D, "sw32", 2, 1'b0);
        check("sw32.be", 32'(log_be[0]), 32'hF);
        check("sw32.wd", log_wd[0], 32'hCAFE_F00D);
        do_op(2, 1'b0, F3_H, 21'hA, 32'h0, "lh32", 2, 1'b0);
        check("lh32.be", 32'(log_be[0]), 32'hC);
        check("lh32.rdata", rdata_a[2], 32'hFFFF_CAFE);

        // ---------------- reset during beat 2 of a BUSW = 8 SW ----------------
        @(negedge clk);
        req_a[0]   = 1'b1;
        store_a[0] = 1'b1;
        f3_a[0]    = F3_W;
        addr_a[0]  = 21'h20;
        wdata_a[0] = 32'h1122_3344;
        @(negedge clk);
        req_a[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("rrst.b2_ad", 32'(ad_a[0]), 32'h22);
        check("rrst.b2_we", 32'(we_a[0]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rrst.idle", 32'({busy_a[0], ready_a[0], err_a[0], we_a[0]}), 32'h0);
        check("rrst.rdata", rdata_a[0], 32'h0);
        seen_rdy = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready_a[0] || we_a[0]) seen_rdy++;
        end
        check("rrst.quiet", 32'(seen_rdy), 32'd0);
        do_op(0, 1'b0, F3_BU, 21'h20, 32'h0, "rrst.lb0", 2, 1'b0);
        check("rrst.lb0.rdata", rdata_a[0], 32'h0000_0044);
        do_op(0, 1'b0, F3_BU, 21'h21, 32'h0, "rrst.lb1", 2, 1'b0);
        check("rrst.lb1.rdata", rdata_a[0], 32'h0000_0033);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
